eprom_read_sequencer: RTL and testbench
=======================================

Name: eprom_read_sequencer

Overview:
- Synchronous read controller directly upstream of the 27512-class EPROM models in the System86 simulation.
- Converts a clocked request/valid handshake into EPROM control strobes: address, active-low chip enable E and active-low output enable G.
- Counts wait states to honour access, OE and float timings, samples Q and returns the data.
- A one-entry last-address cache lets repeated reads of the same location (e.g. CPU opcode re-fetch, tile ROM reuse) complete without a ROM cycle.

Parameters:
- ADDR_WIDTH, 16, EPROM address width.
- DATA_WIDTH, 8, EPROM data width.
- ACCESS_CYCLES, 7, clocks E is held low per access; must cover tAVQV/tELQV (7 x 40 ns = 280 ns > 250 ns).
- OE_CYCLES, 3, clocks G is low, aligned to the end of the E window; must cover tGLQV (120 ns > 100 ns).
- RECOVER_CYCLES, 2, clocks with E/G high after an access before the next one; covers tEHQZ/tGHQZ (80 ns > 60 ns); 0 allowed.
- HIT_ENABLE, 1, enables the last-address cache.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- REQ  in  1  read request, sampled on CLK rising edge
- ADDR  in  ADDR_WIDTH  read address, sampled with REQ
- INVALIDATE  in  1  clears cache valid
- BUSY  out  1  controller cannot accept REQ
- DVALID  out  1  one-cycle pulse: DOUT holds read data
- DOUT  out  DATA_WIDTH  read data, held until next DVALID
- ROM_A  out  ADDR_WIDTH  EPROM address
- ROM_E  out  1  EPROM chip enable, active low
- ROM_G  out  1  EPROM output enable, active low
- ROM_Q  in  DATA_WIDTH  EPROM data

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-high on RST.
- Reset values:
  - BUSY=0, DVALID=0, DOUT=0, ROM_A=0, ROM_E=1, ROM_G=1.
  - Cache valid=0, cache address/data=0, counter=0, state=IDLE.
- RST mid-access: everything returns to reset values at that edge. No DVALID is produced for the aborted access.
- States: IDLE, ACCESS, RECOVER.
- IDLE, REQ=1, hit (HIT_ENABLE=1, cache valid, ADDR==cache address, INVALIDATE=0):
  - DOUT<=cache data, DVALID=1 next cycle.
  - BUSY stays 0 and ROM_E/ROM_G stay high.
  - Back-to-back hits are allowed every cycle.
- IDLE, REQ=1, otherwise (miss), at edge 0:
  - ROM_A<=ADDR, ROM_E<=0, BUSY<=1, counter<=ACCESS_CYCLES-1, go to ACCESS.
- ACCESS:
  - ROM_G is 0 during the final OE_CYCLES cycles of the window: cycles where counter < OE_CYCLES.
  - At edge ACCESS_CYCLES: DOUT<=ROM_Q, DVALID<=1 for one cycle, cache<= {ROM_A, ROM_Q}, valid<=1.
  - At the same edge ROM_E<=1 and ROM_G<=1.
  - Then go to RECOVER (counter<=RECOVER_CYCLES-1), or to IDLE with BUSY<=0 if RECOVER_CYCLES=0.
- RECOVER: strobes stay high. After RECOVER_CYCLES clocks, go to IDLE with BUSY<=0.
- Next REQ: earliest sampled at edge ACCESS_CYCLES+RECOVER_CYCLES+1.
- ROM_A hold: ROM_A is held after the access until the next miss (tAXQX hold).
- REQ while BUSY=1 is ignored and not queued. The requester re-issues.
- INVALIDATE:
  - Clears valid at the next edge.
  - In the same cycle as a REQ, that REQ is treated as a miss.
  - Coincident with access completion, invalidate wins: data is still delivered but valid=0.
- Cache compares the full ADDR_WIDTH bits.
- Elaboration check: $error unless ACCESS_CYCLES>=1, 1<=OE_CYCLES<=ACCESS_CYCLES, RECOVER_CYCLES>=0.

Decomposition:
- Shared include system86_mem_defs.vh holds:
  - state encodings IDLE/ACCESS/RECOVER;
  - function ns_to_cycles(ns, period_ns) (ceiling), used to derive the cycle parameters from EPROM timing parameters.
- One sub-module: mem_wait_counter, a loadable down-counter with a zero flag, reused for the ACCESS and RECOVER windows.

Test Plan:
All cases use a 40 ns clock, default parameters, and the sequencer driving the 27512 model loaded with mem[a] = a[7:0] ^ a[15:8].
1. Reset, then REQ ADDR=0x12A5 -> ROM_E low for 7 cycles; ROM_G low for the last 3; DVALID one cycle after edge 7 with DOUT=0xB7, never X; BUSY high for 9 cycles.
2. Repeat REQ 0x12A5 after BUSY falls -> DVALID next cycle, DOUT=0xB7, ROM_E never falls; then 4 consecutive-cycle REQs 0x12A5 -> 4 consecutive DVALIDs.
3. REQ 0x0001 while BUSY -> no extra DVALID; ROM_A stays 0x12A5; after idle, REQ 0x0001 -> DOUT=0x01 after a full access.
4. INVALIDATE pulse, then REQ 0x0001 -> full 7-cycle ROM access, DOUT=0x01.
5. RST at cycle 4 of an access to 0x3C00 -> next edge ROM_E=ROM_G=1, BUSY=0, DVALID never asserted; following REQ 0x3C00 is a miss.
6. REQ 0xFFFF then REQ 0x0000 -> DOUT=0x00 then 0x00, both full misses; REQ 0xFFFE -> DOUT=0x01, miss (full-width compare).

Source files
------------

// File: rtl/eprom_read_sequencer_pkg.sv
// eprom_read_sequencer_pkg: state encodings, counter width and EPROM timing helpers
package eprom_read_sequencer_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;
  localparam int CNT_W = 8;
  localparam int T_CLK_NS = 40;
  localparam int T_ACC_NS = 250;
  localparam int T_OE_NS = 100;
  localparam int T_DF_NS = 60;
  function automatic int ns_to_cycles(input int ns, input int period_ns);
    return (ns + period_ns - 1) / period_ns;
  endfunction
endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable down-counter that parks at zero and flags it
module mem_wait_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic [W-1:0] cnt,
  output logic         zero
);
  assign zero = cnt == '0;
  // load wins over counting; counting stops once zero is reached
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (!zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/eprom_read_sequencer.sv
// eprom_read_sequencer: req/valid to 27512 EPROM strobe sequencer with a last-address cache
module eprom_read_sequencer
  import eprom_read_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACCESS_CYCLES = ns_to_cycles(T_ACC_NS, T_CLK_NS),
  parameter int OE_CYCLES = ns_to_cycles(T_OE_NS, T_CLK_NS),
  parameter int RECOVER_CYCLES = ns_to_cycles(T_DF_NS, T_CLK_NS),
  parameter int HIT_ENABLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  invalidate,
  output logic                  busy,
  output logic                  dvalid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH-1:0] rom_a,
  output logic                  rom_e,
  output logic                  rom_g,
  input  logic [DATA_WIDTH-1:0] rom_q
);
  if (!(ACCESS_CYCLES >= 1 && OE_CYCLES >= 1 && OE_CYCLES <= ACCESS_CYCLES && RECOVER_CYCLES >= 0)) begin : g_bad_timing
    $error("eprom_read_sequencer: illegal cycle parameters");
  end
  logic [1:0] state;
  logic valid;
  logic [ADDR_WIDTH-1:0] cache_a;
  logic [DATA_WIDTH-1:0] cache_d;
  logic [CNT_W-1:0] cnt, load_val;
  logic zero, hit, load;
  assign hit = HIT_ENABLE != 0 && valid && addr == cache_a && !invalidate;
  assign rom_g = !(state == S_ACCESS && cnt < CNT_W'(OE_CYCLES));
  // counter is loaded on a miss start and again when the access window closes
  always_comb begin
    load = (state == S_IDLE && req && !hit) || (state == S_ACCESS && zero && RECOVER_CYCLES > 0);
    load_val = state == S_IDLE ? CNT_W'(ACCESS_CYCLES - 1) : CNT_W'(RECOVER_CYCLES - 1);
  end
  mem_wait_counter #(.W(CNT_W)) u_wait (
    .clk (clk),
    .rst (rst),
    .load(load),
    .val (load_val),
    .cnt (cnt),
    .zero(zero)
  );
  // sequencer: hit service, miss launch, data capture and recovery
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      busy <= 1'b0;
      dvalid <= 1'b0;
      dout <= '0;
      rom_a <= '0;
      rom_e <= 1'b1;
      valid <= 1'b0;
      cache_a <= '0;
      cache_d <= '0;
    end else begin
      dvalid <= 1'b0;
      if (invalidate) valid <= 1'b0;
      if (state == S_IDLE) begin
        if (req && hit) begin
          dout <= cache_d;
          dvalid <= 1'b1;
        end else if (req) begin
          rom_a <= addr;
          rom_e <= 1'b0;
          busy <= 1'b1;
          state <= S_ACCESS;
        end
      end else if (state == S_ACCESS) begin
        if (zero) begin
          dout <= rom_q;
          dvalid <= 1'b1;
          cache_a <= rom_a;
          cache_d <= rom_q;
          valid <= !invalidate;
          rom_e <= 1'b1;
          busy <= RECOVER_CYCLES > 0;
          state <= RECOVER_CYCLES > 0 ? S_RECOVER : S_IDLE;
        end
      end else if (zero) begin
        busy <= 1'b0;
        state <= S_IDLE;
      end
    end
endmodule

// File: tb/tb_eprom_read_sequencer.sv
// tb_eprom_read_sequencer: transaction table, corner sequences and random traffic vs a reference model
module tb_eprom_read_sequencer;
  localparam int ACC = 7;
  localparam int OE = 3;
  localparam int REC = 2;
  logic clk = 1'b0;
  logic rst, req, inv;
  logic [15:0] addr;
  logic busy, dvalid, rom_e, rom_g;
  logic [7:0] dout;
  logic [15:0] rom_a;
  logic [7:0] rom_q = 8'hEE;
  int n_chk = 0, n_fail = 0, n = 0;
  int dv_cnt = 0;
  logic e_fell = 1'b0;
  int e_cnt = 0, g_cnt = 0;

  always #20 clk = ~clk;

  eprom_read_sequencer dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .invalidate(inv),
    .busy(busy), .dvalid(dvalid), .dout(dout),
    .rom_a(rom_a), .rom_e(rom_e), .rom_g(rom_g), .rom_q(rom_q)
  );

  function automatic logic [7:0] f(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // EPROM model: data is only valid once E has been low 7 cycles and G low 3 cycles
  always @(negedge clk) begin
    e_cnt <= rom_e ? 0 : e_cnt + 1;
    g_cnt <= rom_g ? 0 : g_cnt + 1;
    rom_q <= (!rom_e && e_cnt >= ACC - 1 && !rom_g && g_cnt >= OE - 1) ? f(rom_a) : 8'hEE;
  end

  // transaction-level reference: cache contents, miss start cycle, delivery cycle, free cycle
  logic mv = 1'b0;
  logic [15:0] ma = '0, pa = '0, xa = '0;
  logic [7:0] md = '0, xd = '0;
  logic xdv = 1'b0;
  int ms = -100, mdv = -1, mbe = 0;

  task automatic model(input logic r, input logic q, input logic [15:0] a, input logic i);
    logic h;
    if (r) begin
      mv = 0; ma = '0; md = '0; ms = -100; mdv = -1; mbe = 0; xa = '0; xd = '0; xdv = 0;
    end else begin
      xdv = 0;
      h = mv && a == ma && !i;
      if (n == mdv) begin
        xdv = 1; xd = f(pa); ma = pa; md = f(pa); mv = 1;
      end
      if (i) mv = 0;
      if (n >= mbe && q) begin
        if (h) begin
          xdv = 1; xd = md;
        end else begin
          ms = n; mdv = n + ACC; mbe = n + ACC + REC + 1; pa = a; xa = a;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, n, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic q, input logic [15:0] a, input logic i);
    rst = r; req = q; addr = a; inv = i;
    @(posedge clk);
    model(r, q, a, i);
    #1;
    chk("dvalid", {31'b0, dvalid}, {31'b0, xdv});
    chk("dout", {24'b0, dout}, {24'b0, xd});
    chk("busy", {31'b0, busy}, {31'b0, n + 1 < mbe});
    chk("rom_e", {31'b0, rom_e}, {31'b0, !(n >= ms && n <= ms + ACC - 1)});
    chk("rom_g", {31'b0, rom_g}, {31'b0, !(n >= ms + ACC - OE && n <= ms + ACC - 1)});
    chk("rom_a", {16'b0, rom_a}, {16'b0, xa});
    if (!rom_e) e_fell = 1;
    if (dvalid) dv_cnt++;
    n++;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic inv;
    logic pester;
    logic [7:0] exp_data;
    logic exp_hit;
  } txn_t;

  task automatic run_txn(input txn_t t);
    int k = 0;
    int lat = 1;
    while (busy && k < 20) begin
      step(0, t.pester, 16'h0001, 0);
      k++;
    end
    chk("txn_idle_timeout", {31'b0, busy}, 32'd0);
    if (t.inv) step(0, 0, 16'h0, 1);
    e_fell = 0;
    step(0, 1, t.addr, 0);
    while (!dvalid && lat < 20) begin
      step(0, t.pester, 16'h0001, 0);
      lat++;
    end
    chk("txn_data", {24'b0, dout}, {24'b0, t.exp_data});
    chk("txn_latency", lat, t.exp_hit ? 1 : ACC + 1);
    chk("txn_rom_e_fell", {31'b0, e_fell}, {31'b0, !t.exp_hit});
    dv_cnt = 0;
    k = 0;
    while (busy && k < 20) begin
      step(0, t.pester, 16'h0001, 0);
      k++;
    end
    chk("txn_extra_dvalid", dv_cnt, 0);
  endtask

  txn_t tbl[8];
  logic [15:0] pick[4];

  initial begin
    tbl[0] = '{16'h12A5, 1'b0, 1'b1, 8'hB7, 1'b0};
    tbl[1] = '{16'h12A5, 1'b0, 1'b0, 8'hB7, 1'b1};
    tbl[2] = '{16'h0001, 1'b0, 1'b0, 8'h01, 1'b0};
    tbl[3] = '{16'h0001, 1'b1, 1'b0, 8'h01, 1'b0};
    tbl[4] = '{16'h3C00, 1'b0, 1'b0, 8'h3C, 1'b0};
    tbl[5] = '{16'hFFFF, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[6] = '{16'h0000, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[7] = '{16'hFFFE, 1'b0, 1'b0, 8'h01, 1'b0};
    step(1, 0, 16'h0, 0);
    step(1, 0, 16'h0, 0);
    run_txn(tbl[0]);
    run_txn(tbl[1]);
    dv_cnt = 0;
    for (int i = 0; i < 4; i++) step(0, 1, 16'h12A5, 0);
    chk("hit_burst_count", dv_cnt, 4);
    run_txn(tbl[2]);
    run_txn(tbl[3]);
    step(0, 1, 16'h3C00, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0);
    step(1, 0, 16'h0, 0);
    dv_cnt = 0;
    for (int i = 0; i < 12; i++) step(0, 0, 16'h0, 0);
    chk("abort_no_dvalid", dv_cnt, 0);
    for (int i = 4; i < 8; i++) run_txn(tbl[i]);
    pick[0] = 16'h12A5; pick[1] = 16'h0001; pick[2] = 16'hFFFF; pick[3] = 16'h0000;
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      a = $urandom_range(0, 4) == 4 ? 16'($urandom) : pick[$urandom_range(0, 3)];
      step($urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1, a, $urandom_range(0, 99) < 8);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
